// File: rtl/sad_scan_pkg.sv
// Shared defaults, FSM state encoding and helpers for the SAD window scan controller.
package sad_scan_pkg;
  localparam int FRAME_COLS_DEF = 64;
  localparam int FRAME_ROWS_DEF = 64;
  localparam int WIN_DEF        = 4;
  localparam int POS_W          = 8;

  localparam logic [31:0] SAD_INIT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic logic [31:0] word_index(input logic [POS_W-1:0] row,
                                             input logic [POS_W-1:0] col,
                                             input int               cols);
    return 32'(row) * 32'(cols) + 32'(col);
  endfunction
endpackage

// File: rtl/sad_scan_pos_ctr.sv
// Raster row/column counter over all window top-left positions, with a last-position flag.
module sad_scan_pos_ctr
  import sad_scan_pkg::*;
#(
  parameter int FRAME_COLS = FRAME_COLS_DEF,
  parameter int FRAME_ROWS = FRAME_ROWS_DEF,
  parameter int WIN        = WIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_advance,
  output logic [POS_W-1:0] o_row,
  output logic [POS_W-1:0] o_col,
  output logic             o_last
);
  localparam logic [POS_W-1:0] COL_MAX = POS_W'(FRAME_COLS - WIN);
  localparam logic [POS_W-1:0] ROW_MAX = POS_W'(FRAME_ROWS - WIN);

  logic [POS_W-1:0] r_row;
  logic [POS_W-1:0] r_col;
  logic             w_col_wrap;

  assign w_col_wrap = (r_col == COL_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_clear) begin
      r_row <= '0;
      r_col <= '0;
    end else if (i_advance) begin
      if (w_col_wrap) begin
        r_col <= '0;
        r_row <= r_row + POS_W'(1);
      end else begin
        r_col <= r_col + POS_W'(1);
      end
    end
  end

  assign o_row  = r_row;
  assign o_col  = r_col;
  assign o_last = w_col_wrap && (r_row == ROW_MAX);
endmodule

// File: rtl/sad_scan_ctrl.sv
// Scans every window position of a frame, offers each address downstream and keeps the
// earliest strictly-smallest SAD; one position per ISSUE/WAIT pair, done pulses once at the end.
module sad_scan_ctrl
  import sad_scan_pkg::*;
#(
  parameter int FRAME_COLS = FRAME_COLS_DEF,
  parameter int FRAME_ROWS = FRAME_ROWS_DEF,
  parameter int WIN        = WIN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pos_ready,
  input  logic             sad_valid,
  input  logic [31:0]      sad_in,
  output logic [31:0]      current_address,
  output logic             pos_valid,
  output logic             busy,
  output logic             done,
  output logic [31:0]      best_sad,
  output logic [POS_W-1:0] best_row,
  output logic [POS_W-1:0] best_col,
  output logic [31:0]      best_address
);
  state_t           r_state;
  state_t           w_next;
  logic             w_clear;
  logic             w_advance;
  logic             w_take;
  logic             w_better;
  logic             w_last;
  logic [POS_W-1:0] w_row;
  logic [POS_W-1:0] w_col;
  logic [31:0]      w_addr;

  logic [31:0]      r_best_sad;
  logic [POS_W-1:0] r_best_row;
  logic [POS_W-1:0] r_best_col;
  logic [31:0]      r_best_addr;

  sad_scan_pos_ctr #(
    .FRAME_COLS (FRAME_COLS),
    .FRAME_ROWS (FRAME_ROWS),
    .WIN        (WIN)
  ) u_pos_ctr (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_advance (w_advance),
    .o_row     (w_row),
    .o_col     (w_col),
    .o_last    (w_last)
  );

  // Derived straight from the counter registers, so it is stable while ISSUE waits.
  assign w_addr          = word_index(w_row, w_col, FRAME_COLS);
  assign current_address = w_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_clear   = 1'b0;
    w_advance = 1'b0;
    w_take    = 1'b0;
    pos_valid = 1'b0;
    done      = 1'b0;
    busy      = (r_state != IDLE);
    case (r_state)
      IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = ISSUE;
        end
      end
      ISSUE: begin
        pos_valid = 1'b1;
        if (pos_ready) begin
          w_next = WAIT;
        end
      end
      WAIT: begin
        if (sad_valid) begin
          w_take = 1'b1;
          if (w_last) begin
            w_next = DONE;
          end else begin
            w_advance = 1'b1;
            w_next    = ISSUE;
          end
        end
      end
      DONE: begin
        done   = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Strict compare: a tie never displaces an earlier position in raster order.
  assign w_better = w_take && (sad_in < r_best_sad);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_best_sad  <= SAD_INIT;
      r_best_row  <= '0;
      r_best_col  <= '0;
      r_best_addr <= '0;
    end else if (w_clear) begin
      r_best_sad  <= SAD_INIT;
      r_best_row  <= '0;
      r_best_col  <= '0;
      r_best_addr <= '0;
    end else if (w_better) begin
      r_best_sad  <= sad_in;
      r_best_row  <= w_row;
      r_best_col  <= w_col;
      r_best_addr <= w_addr;
    end
  end

  assign best_sad     = r_best_sad;
  assign best_row     = r_best_row;
  assign best_col     = r_best_col;
  assign best_address = r_best_addr;
endmodule

// File: tb/tb_sad_scan_ctrl.sv
// Scoreboard bench for sad_scan_ctrl: expected addresses and best results are queued at stimulus time.
module tb_sad_scan_ctrl;
  localparam int COLS      = 64;
  localparam int ROWS      = 64;
  localparam int WINW      = 4;
  localparam int LAST_ADDR = (ROWS - WINW) * COLS + (COLS - WINW);

  typedef struct {
    logic [31:0] sad;
    logic [7:0]  row;
    logic [7:0]  col;
    logic [31:0] addr;
  } best_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pos_ready = 1'b0;
  logic        sad_valid = 1'b0;
  logic [31:0] sad_in = '0;
  logic [31:0] current_address;
  logic        pos_valid;
  logic        busy;
  logic        done;
  logic [31:0] best_sad;
  logic [7:0]  best_row;
  logic [7:0]  best_col;
  logic [31:0] best_address;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          addr_q[$];
  best_t       best_q[$];

  int          stall_addr      = -1;
  int          stall_len       = 0;
  bit          inject_spurious = 1'b0;
  int          start_wait_addr = -1;
  int          abort_addr      = -1;
  bit          aborted;

  sad_scan_ctrl #(.FRAME_COLS(COLS), .FRAME_ROWS(ROWS), .WIN(WINW)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .pos_ready       (pos_ready),
    .sad_valid       (sad_valid),
    .sad_in          (sad_in),
    .current_address (current_address),
    .pos_valid       (pos_valid),
    .busy            (busy),
    .done            (done),
    .best_sad        (best_sad),
    .best_row        (best_row),
    .best_col        (best_col),
    .best_address    (best_address)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] sad_for(input int mode, input int r, input int c);
    case (mode)
      1:       return (r == 10 && c == 20) ? 32'd5 : 32'd1000;
      2:       return 32'd7;
      3:       return (r == 1 && c == 0) ? 32'd9 : 32'd40;
      4:       return (r == 2 && c == 5) ? 32'd3 : 32'd50;
      6:       return (r == 60 && c == 60) ? 32'd0 : 32'd20;
      default: return 32'd1000;
    endcase
  endfunction

  task automatic run_scan(input int mode);
    int          cycles;
    int          stall_left;
    int          a;
    int          exp_a;
    bit          stalling;
    bit          stall_used;
    bit          in_wait;
    bit          last_drv;
    bit          accept;
    bit          scan_done;
    logic [31:0] acc_addr;
    addr_q.delete();
    for (int r = 0; r <= ROWS - WINW; r++)
      for (int c = 0; c <= COLS - WINW; c++)
        addr_q.push_back(r * COLS + c);
    aborted = 1'b0;
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_after_start got %b want 1", busy);
    end
    cycles = 0; stalling = 0; stall_used = 0; stall_left = 0;
    in_wait = 0; last_drv = 0; scan_done = 0; acc_addr = '0;
    while (cycles < 10000) begin
      if (last_drv) begin
        n_cmp++;
        if (done !== 1'b1) begin
          n_fail++; $display("FAIL done_after_last got %b want 1", done);
        end
        scan_done = 1;
        break;
      end
      if (done === 1'b1) begin
        n_cmp++; n_fail++;
        $display("FAIL early_done at cycle %0d got 1 want 0", cycles);
      end
      pos_ready = 1'b0; sad_valid = 1'b0; sad_in = '0; start = 1'b0;
      accept = 0;
      if (in_wait) begin
        n_cmp++;
        if (pos_valid !== 1'b0) begin
          n_fail++; $display("FAIL wait_pos_valid got %b want 0", pos_valid);
        end
        a = int'(acc_addr);
        sad_valid = 1'b1;
        sad_in    = sad_for(mode, a / COLS, a % COLS);
        if (a == start_wait_addr) start = 1'b1;
        last_drv = (a == LAST_ADDR);
        in_wait  = 0;
      end else if (pos_valid === 1'b1 || stalling) begin
        if (int'(current_address) == abort_addr) begin
          aborted = 1'b1;
          break;
        end
        if (!stalling && !stall_used && int'(current_address) == stall_addr) begin
          stalling = 1; stall_used = 1; stall_left = stall_len;
        end
        if (stalling) begin
          n_cmp++;
          if (pos_valid !== 1'b1 || int'(current_address) != stall_addr) begin
            n_fail++;
            $display("FAIL stall_hold got valid=%b addr=%0d want valid=1 addr=%0d",
                     pos_valid, current_address, stall_addr);
          end
          if (stall_left > 0) begin
            stall_left--;
            if (inject_spurious) begin
              sad_valid = 1'b1; sad_in = '0;
            end
          end else begin
            stalling = 0; accept = 1;
          end
        end else begin
          accept = 1;
        end
        if (accept) begin
          pos_ready = 1'b1;
          acc_addr  = current_address;
          n_cmp++;
          if (addr_q.size() == 0) begin
            n_fail++; $display("FAIL addr_extra got %0d want none", acc_addr);
          end else begin
            exp_a = addr_q.pop_front();
            if (int'(acc_addr) != exp_a) begin
              n_fail++; $display("FAIL addr_seq got %0d want %0d", acc_addr, exp_a);
            end
          end
          in_wait = 1;
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    pos_ready = 1'b0; sad_valid = 1'b0; sad_in = '0; start = 1'b0;
    if (aborted) return;
    if (!scan_done) begin
      n_cmp++; n_fail++;
      $display("FAIL scan_timeout got %0d cycles want done", cycles);
      return;
    end
    n_cmp++;
    if (addr_q.size() != 0) begin
      n_fail++; $display("FAIL addr_missing got %0d left want 0", addr_q.size());
    end
    @(posedge clk); #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL done_one_cycle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({pos_valid, busy, done} !== 3'b000 || current_address !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl got v=%b b=%b d=%b addr=%0d want 0 0 0 0",
               pos_valid, busy, done, current_address);
    end
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {32'hFFFF_FFFF, 8'd0, 8'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL reset_best got %h/%0d/%0d/%0d want ffffffff/0/0/0",
               best_sad, best_row, best_col, best_address);
    end
    start = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset got busy=%b want 0", busy);
    end
  endtask

  task automatic test_single_min();
    best_t e;
    best_q.push_back('{32'd5, 8'd10, 8'd20, 32'd660});
    run_scan(1);
    e = best_q.pop_front();
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {e.sad, e.row, e.col, e.addr}) begin
      n_fail++;
      $display("FAIL single_min got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               best_sad, best_row, best_col, best_address, e.sad, e.row, e.col, e.addr);
    end
  endtask

  task automatic test_tie();
    best_t e;
    best_q.push_back('{32'd7, 8'd0, 8'd0, 32'd0});
    run_scan(2);
    e = best_q.pop_front();
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {e.sad, e.row, e.col, e.addr}) begin
      n_fail++;
      $display("FAIL tie_first got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               best_sad, best_row, best_col, best_address, e.sad, e.row, e.col, e.addr);
    end
  endtask

  task automatic test_stall();
    best_t e;
    stall_addr = 60; stall_len = 5;
    best_q.push_back('{32'd9, 8'd1, 8'd0, 32'd64});
    run_scan(3);
    stall_addr = -1; stall_len = 0;
    e = best_q.pop_front();
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {e.sad, e.row, e.col, e.addr}) begin
      n_fail++;
      $display("FAIL stall_best got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               best_sad, best_row, best_col, best_address, e.sad, e.row, e.col, e.addr);
    end
  endtask

  task automatic test_ignore();
    best_t e;
    stall_addr = 100; stall_len = 2; inject_spurious = 1'b1; start_wait_addr = 200;
    best_q.push_back('{32'd3, 8'd2, 8'd5, 32'd133});
    run_scan(4);
    stall_addr = -1; stall_len = 0; inject_spurious = 1'b0; start_wait_addr = -1;
    e = best_q.pop_front();
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {e.sad, e.row, e.col, e.addr}) begin
      n_fail++;
      $display("FAIL ignore_best got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               best_sad, best_row, best_col, best_address, e.sad, e.row, e.col, e.addr);
    end
  endtask

  task automatic test_abort();
    bit saw_done;
    abort_addr = 30 * COLS + 15;
    run_scan(1);
    abort_addr = -1;
    n_cmp++;
    if (!aborted) begin
      n_fail++; $display("FAIL abort_reach got 0 want 1");
      return;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({pos_valid, busy, done} !== 3'b000 || current_address !== 32'd0) begin
      n_fail++;
      $display("FAIL abort_async_ctrl got v=%b b=%b d=%b addr=%0d want 0 0 0 0",
               pos_valid, busy, done, current_address);
    end
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {32'hFFFF_FFFF, 8'd0, 8'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL abort_async_best got %h/%0d/%0d/%0d want ffffffff/0/0/0",
               best_sad, best_row, best_col, best_address);
    end
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) saw_done = 1'b1;
      if (i == 1) rst = 1'b0;
    end
    n_cmp++;
    if (saw_done || busy !== 1'b0) begin
      n_fail++; $display("FAIL abort_no_done got done_seen=%b busy=%b want 0 0", saw_done, busy);
    end
  endtask

  task automatic test_last_min();
    best_t e;
    best_q.push_back('{32'd0, 8'd60, 8'd60, 32'd3900});
    run_scan(6);
    e = best_q.pop_front();
    n_cmp++;
    if ({best_sad, best_row, best_col, best_address} !== {e.sad, e.row, e.col, e.addr}) begin
      n_fail++;
      $display("FAIL last_min got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
               best_sad, best_row, best_col, best_address, e.sad, e.row, e.col, e.addr);
    end
  endtask

  initial begin
    test_reset();
    test_single_min();
    test_stall();
    test_ignore();
    test_abort();
    test_tie();
    test_last_min();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
